// File: rtl/four_bit_dff_down_counter_syn_clock_pkg.sv
// Shared definitions for the DFF-based synchronous down counter:
// state encoding and default counter width.
`ifndef FOUR_BIT_DFF_DOWN_COUNTER_SYN_CLOCK_PKG_SV
`define FOUR_BIT_DFF_DOWN_COUNTER_SYN_CLOCK_PKG_SV

package four_bit_dff_down_counter_syn_clock_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

endpackage

`endif

// File: rtl/four_bit_dff_down_counter_syn_clock_if.sv
// Control/status bundle of the down counter; clock and reset stay plain ports.
interface four_bit_dff_down_counter_syn_clock_if
    import four_bit_dff_down_counter_syn_clock_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic             En;
    logic             Load;
    logic [WIDTH-1:0] LoadVal;
    logic             OneShot;
    logic [WIDTH-1:0] count;
    logic             Zero;
    logic             Borrow;
    logic             Busy;

    modport master (
        output En, Load, LoadVal, OneShot,
        input  count, Zero, Borrow, Busy
    );

    modport slave (
        input  En, Load, LoadVal, OneShot,
        output count, Zero, Borrow, Busy
    );

endinterface

// File: rtl/four_bit_dff_down_counter_syn_clock_dff.sv
// Positive-edge D flip-flop with synchronous active-high clear to a
// configurable value; the single storage primitive of the counter.
module d_flip_flop_pos_clk_syn_rst #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic D,
    input  logic Clk,
    input  logic Clr,
    output logic Q,
    output logic Qbar
);

    always_ff @(posedge Clk) begin
        if (Clr) begin
            Q <= RESET_VAL;
        end else begin
            Q <= D;
        end
    end

    assign Qbar = ~Q;

endmodule

// File: rtl/four_bit_dff_down_counter_syn_clock.sv
// Synchronous down counter with load, enable, wrap/one-shot mode and a
// registered borrow pulse; every state bit is a d_flip_flop_pos_clk_syn_rst.
module four_bit_dff_down_counter_syn_clock
    import four_bit_dff_down_counter_syn_clock_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic Clk,
    input  logic Clr,
    four_bit_dff_down_counter_syn_clock_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_qbar;
    logic [WIDTH-1:0] cnt_d;
    logic             state_bit;
    logic             state_bit_n;
    state_t           state_q;
    state_t           state_d;
    logic             borrow_q;
    logic             borrow_d;
    logic             unused_borrow_n;

    // Count flops preset to MAX on Clr; state and borrow clear to RUN / 0.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cnt
        d_flip_flop_pos_clk_syn_rst #(.RESET_VAL(1'b1)) u_cnt (
            .D    (cnt_d[i]),
            .Clk  (Clk),
            .Clr  (Clr),
            .Q    (cnt_q[i]),
            .Qbar (cnt_qbar[i])
        );
    end

    d_flip_flop_pos_clk_syn_rst #(.RESET_VAL(ST_RUN)) u_state (
        .D    (state_d),
        .Clk  (Clk),
        .Clr  (Clr),
        .Q    (state_bit),
        .Qbar (state_bit_n)
    );

    d_flip_flop_pos_clk_syn_rst #(.RESET_VAL(1'b0)) u_borrow (
        .D    (borrow_d),
        .Clk  (Clk),
        .Clr  (Clr),
        .Q    (borrow_q),
        .Qbar (unused_borrow_n)
    );

    // Next-state: Load beats En; DONE only leaves through Load or Clr.
    always_comb begin
        state_q  = state_t'(state_bit);
        cnt_d    = cnt_q;
        state_d  = state_q;
        borrow_d = 1'b0;
        if (bus.Load) begin
            cnt_d   = bus.LoadVal;
            state_d = ST_RUN;
        end else if (state_q == ST_RUN && bus.En) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - WIDTH'(1);
            end else if (!bus.OneShot) begin
                cnt_d    = MAX;
                borrow_d = 1'b1;
            end else begin
                state_d = ST_DONE;
            end
        end
    end

    always_comb begin
        bus.count  = cnt_q;
        bus.Zero   = &cnt_qbar;
        bus.Borrow = borrow_q;
        bus.Busy   = state_bit_n;
    end

endmodule

// File: tb/tb_four_bit_dff_down_counter_syn_clock.sv
// Scoreboard bench: stimulus pushes hand-computed expectations per edge,
// a negedge monitor pops and compares against the DUT outputs.
module tb_four_bit_dff_down_counter_syn_clock;

    typedef struct {
        bit         casc;
        logic [3:0] c;
        logic       z;
        logic       b;
        logic       busy;
        logic [3:0] c1;
    } exp_t;

    logic Clk = 1'b0;
    logic Clr;
    logic clr_c;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    always #5 Clk = ~Clk;

    four_bit_dff_down_counter_syn_clock_if #(.WIDTH(4)) dif ();
    four_bit_dff_down_counter_syn_clock_if #(.WIDTH(4)) ci0 ();
    four_bit_dff_down_counter_syn_clock_if #(.WIDTH(4)) ci1 ();

    four_bit_dff_down_counter_syn_clock #(.WIDTH(4)) u_dut (
        .Clk (Clk), .Clr (Clr), .bus (dif.slave)
    );
    four_bit_dff_down_counter_syn_clock #(.WIDTH(4)) u_s0 (
        .Clk (Clk), .Clr (clr_c), .bus (ci0.slave)
    );
    four_bit_dff_down_counter_syn_clock #(.WIDTH(4)) u_s1 (
        .Clk (Clk), .Clr (clr_c), .bus (ci1.slave)
    );

    assign ci1.En = ci0.Borrow;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.casc) begin
                chk("s0_count", 32'(ci0.count), 32'(e.c));
                chk("s0_borrow", 32'(ci0.Borrow), 32'(e.b));
                chk("s1_count", 32'(ci1.count), 32'(e.c1));
            end else begin
                chk("count", 32'(dif.count), 32'(e.c));
                chk("zero", 32'(dif.Zero), 32'(e.z));
                chk("borrow", 32'(dif.Borrow), 32'(e.b));
                chk("busy", 32'(dif.Busy), 32'(e.busy));
            end
        end
    end

    task automatic step(input logic clr, input logic en, input logic ld, input logic [3:0] lv,
                        input logic os, input logic [3:0] ec, input logic ez, input logic eb,
                        input logic ebusy);
        exp_t e;
        Clr = clr; dif.En = en; dif.Load = ld; dif.LoadVal = lv; dif.OneShot = os;
        @(posedge Clk);
        e.casc = 1'b0; e.c = ec; e.z = ez; e.b = eb; e.busy = ebusy; e.c1 = 4'h0;
        q.push_back(e);
        #1;
    endtask

    task automatic cstep(input logic clr, input logic en, input logic [3:0] ec0,
                         input logic eb0, input logic [3:0] ec1);
        exp_t e;
        clr_c = clr; ci0.En = en;
        @(posedge Clk);
        e.casc = 1'b1; e.c = ec0; e.z = 1'b0; e.b = eb0; e.busy = 1'b1; e.c1 = ec1;
        q.push_back(e);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        Clr = 1'b1; clr_c = 1'b1;
        dif.En = 1'b0; dif.Load = 1'b0; dif.LoadVal = 4'h0; dif.OneShot = 1'b0;
        ci0.En = 1'b0; ci0.Load = 1'b0; ci0.LoadVal = 4'h0; ci0.OneShot = 1'b0;
        ci1.Load = 1'b0; ci1.LoadVal = 4'h0; ci1.OneShot = 1'b0;
        @(posedge Clk); #1;

        // reset, then a full wrap F..0,F
        step(1, 0, 0, 4'h0, 0, 4'hF, 0, 0, 1);
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] ec;
            ec = 4'(15 - k);
            step(0, 1, 0, 4'h0, 0, ec, ec == 4'h0, k == 16, 1);
        end

        // one-shot from 3 down into DONE
        step(0, 0, 1, 4'h3, 1, 4'h3, 0, 0, 1);
        step(0, 1, 0, 4'h0, 1, 4'h2, 0, 0, 1);
        step(0, 1, 0, 4'h0, 1, 4'h1, 0, 0, 1);
        step(0, 1, 0, 4'h0, 1, 4'h0, 1, 0, 1);
        step(0, 1, 0, 4'h0, 1, 4'h0, 1, 0, 0);
        step(0, 1, 0, 4'h0, 1, 4'h0, 1, 0, 0);
        step(0, 1, 0, 4'h0, 0, 4'h0, 1, 0, 0);

        // reload out of DONE and resume
        step(0, 0, 1, 4'h5, 0, 4'h5, 0, 0, 1);
        step(0, 1, 0, 4'h0, 0, 4'h4, 0, 0, 1);
        step(0, 1, 0, 4'h0, 0, 4'h3, 0, 0, 1);

        // load wins over enable, clear wins over load
        step(0, 0, 1, 4'h7, 0, 4'h7, 0, 0, 1);
        step(0, 1, 1, 4'hA, 0, 4'hA, 0, 0, 1);
        step(1, 0, 1, 4'h2, 0, 4'hF, 0, 0, 1);

        // load of zero in both modes
        step(0, 0, 1, 4'h0, 1, 4'h0, 1, 0, 1);
        step(0, 1, 0, 4'h0, 1, 4'h0, 1, 0, 0);
        step(0, 0, 1, 4'h0, 0, 4'h0, 1, 0, 1);
        step(0, 1, 0, 4'h0, 0, 4'hF, 0, 1, 1);
        step(0, 0, 0, 4'h0, 0, 4'hF, 0, 0, 1);

        // clear glitch between edges has no effect, edge-sampled clear does
        step(0, 0, 1, 4'h6, 0, 4'h6, 0, 0, 1);
        Clr = 1'b1; #2; Clr = 1'b0; #1;
        step(0, 0, 0, 4'h0, 0, 4'h6, 0, 0, 1);
        step(1, 1, 0, 4'h0, 0, 4'hF, 0, 0, 1);
        step(0, 1, 0, 4'h0, 0, 4'hE, 0, 0, 1);
        Clr = 1'b0; dif.En = 1'b0;

        // two cascaded stages: stage1 moves one edge after stage0 wraps
        cstep(1, 0, 4'hF, 0, 4'hF);
        for (int k = 1; k <= 20; k++) begin
            cstep(0, 1, 4'(15 - k), k == 16, (k >= 17) ? 4'hE : 4'hF);
        end
        clr_c = 1'b1; ci0.En = 1'b0;

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge Clk);
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
